acc_ctrl_seq: RTL and testbench
===============================

// Module: acc_ctrl_seq
// PURPOSE
//  Parametrised accelerator control sequencer. Decodes an opcode and runs one accelerator
//  channel (of NUM_ACC) through its LOAD/DRAIN data phases, driving per-channel enable and
//  put/get requests plus the RAM read/write enables. Adds an instruction handshake, a
//  watchdog timeout, protocol-error detection and a software abort. Sits between the
//  instruction source and the data router / accelerator bank.
// PARAMETERS
//  NUM_ACC    3      number of accelerator channels (1..2**OP_W-1)
//  OP_W       2      opcode width; opcode k (1..NUM_ACC) selects channel k-1, 0 = NOP
//  TMO_W      16     watchdog counter width
//  TMO_CYC    16'd0  watchdog limit in cycles per phase; 0 disables the watchdog
// PORTS
//  clk               in   1        clock, all state updates on rising edge
//  reset             in   1        asynchronous, active-low reset
//  instr_valid       in   1        opcode valid
//  instr_op          in   OP_W     opcode
//  instr_ready       out  1        sequencer can accept an opcode (state IDLE)
//  sw_abort          in   1        abort the running operation
//  read_done         in   NUM_ACC  per-channel: all input data delivered to accelerator
//  write_done        in   NUM_ACC  per-channel: all results collected from accelerator
//  acc_enable        out  NUM_ACC  one-hot enable of active channel
//  put_req           out  NUM_ACC  one-hot: router must put data into the channel
//  get_req           out  NUM_ACC  one-hot: router must get results from the channel
//  ram_read_enable   out  1        OR of put_req
//  ram_write_enable  out  1        OR of get_req
//  acc_done          out  1        1-cycle pulse: operation completed normally
//  acc_error         out  1        1-cycle pulse: invalid opcode, protocol error, timeout or abort
//  busy              out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async assert): state IDLE, channel reg 0, counter 0; all outputs 0 except instr_ready=1.
//  - All outputs registered/decoded from registered state; inputs act on the next edge (1-cycle latency).
//  - States: IDLE, LOAD, DRAIN, DONE, ABORT. Outputs per state for latched channel ch:
//      IDLE : all 0, instr_ready=1.   LOAD : enable, put, get =1.   DRAIN: enable, get =1.
//      DONE : all 0, acc_done=1.      ABORT: all 0, acc_error=1.
//  - IDLE: instr_valid & op in 1..NUM_ACC -> latch ch=op-1, -> LOAD. op==0 ignored.
//    op>NUM_ACC -> ABORT (error pulse). instr_valid ignored outside IDLE (instr_ready=0).
//  - LOAD: read_done[ch]&write_done[ch] -> DONE; read_done[ch] only -> DRAIN;
//    write_done[ch] without read_done[ch] -> ABORT (protocol error).
//  - DRAIN: write_done[ch] -> DONE. DONE, ABORT: one cycle each, then -> IDLE.
//  - done inputs of non-selected channels are ignored in every state.
//  - sw_abort in LOAD/DRAIN -> ABORT, priority over done inputs and timeout; ignored elsewhere.
//  - Watchdog: counter cleared on entry to LOAD and DRAIN, increments each cycle in them,
//    saturates at 2**TMO_W-1; when counter==TMO_CYC-1 and no exit condition -> ABORT.
//    TMO_CYC=0: never times out. A done arriving on the timeout cycle wins over timeout.
//  - Priority in LOAD/DRAIN: sw_abort > protocol error > done transitions > timeout.
//  - Reset mid-operation: outputs drop asynchronously; no acc_done/acc_error pulse issued.
//  - acc_enable/put_req/get_req are always one-hot or zero; never two channels active.
// TESTING
//  1 Normal ch1 (NUM_ACC=3): op=2 valid @t0 -> t1 enable=010,put=get=010; read_done[1] @t3
//    -> t4 put=000,get=010; write_done[1] @t6 -> t7 acc_done=1, outputs 0; t8 instr_ready=1.
//  2 Simultaneous done: op=3, read_done[2]&write_done[2] same cycle -> DONE directly, no DRAIN cycle.
//  3 Errors: op=0 -> nothing happens; write_done[0] before read_done[0] on op=1 -> one acc_error
//    pulse, no acc_done; with NUM_ACC=2 op=3 -> acc_error pulse, no enable asserted.
//  4 Timeout TMO_CYC=8: op=1, no done -> acc_error on the cycle after the 8th LOAD cycle;
//    done arriving on the 8th cycle -> normal transition, no error.
//  5 sw_abort during DRAIN concurrent with write_done[ch] -> acc_error, no acc_done; reset
//    asserted mid-LOAD -> all outputs 0 immediately, instr_ready=1 after release.
//  6 Cross-channel: op=1 active, read_done/write_done of ch1,ch2 toggled -> no state change.

Source files
------------

// File: rtl/acc_ctrl_seq.sv
// Accelerator control sequencer: decodes an opcode and walks one channel through
// LOAD/DRAIN with handshake, watchdog, protocol-error detection and software abort.
module acc_ctrl_seq #(
  parameter int unsigned      NUM_ACC = 3,
  parameter int unsigned      OP_W    = 2,
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [OP_W-1:0]    instr_op,
  output logic               instr_ready,
  input  logic               sw_abort,
  input  logic [NUM_ACC-1:0] read_done,
  input  logic [NUM_ACC-1:0] write_done,
  output logic [NUM_ACC-1:0] acc_enable,
  output logic [NUM_ACC-1:0] put_req,
  output logic [NUM_ACC-1:0] get_req,
  output logic               ram_read_enable,
  output logic               ram_write_enable,
  output logic               acc_done,
  output logic               acc_error,
  output logic               busy
);

  localparam int unsigned     CH_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam logic [OP_W-1:0] MAX_OP  = OP_W'(NUM_ACC);
  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t            state_q, state_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic [TMO_W-1:0]  cnt_q, cnt_n;

  logic [NUM_ACC-1:0] sel_oh;
  logic               rd_sel, wr_sel, tmo_hit;
  logic [TMO_W-1:0]   cnt_inc;

  logic [NUM_ACC-1:0] oh_n;
  logic [NUM_ACC-1:0] enable_d, put_d, get_d;
  logic               ready_d, done_d, error_d, busy_d;

  // Only the latched channel's done strobes are observed
  assign sel_oh  = NUM_ACC'(1) << ch_q;
  assign rd_sel  = |(read_done & sel_oh);
  assign wr_sel  = |(write_done & sel_oh);
  assign tmo_hit = (TMO_CYC != '0) && (cnt_q == TMO_CYC - TMO_W'(1));
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_W'(1);

  // State, channel, watchdog and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      acc_enable  <= '0;
      put_req     <= '0;
      get_req     <= '0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      acc_done    <= 1'b0;
      acc_error   <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      state_q     <= state_n;
      ch_q        <= ch_n;
      cnt_q       <= cnt_n;
      acc_enable  <= enable_d;
      put_req     <= put_d;
      get_req     <= get_d;
      ram_read_enable  <= |put_d;
      ram_write_enable <= |get_d;
      acc_done    <= done_d;
      acc_error   <= error_d;
      busy        <= busy_d;
      instr_ready <= ready_d;
    end
  end

  // Next-state: abort > protocol error > done > timeout inside a data phase
  always_comb begin
    state_n = state_q;
    ch_n    = ch_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (instr_valid && (instr_op != '0)) begin
          if (instr_op <= MAX_OP) begin
            ch_n    = CH_W'(instr_op - OP_W'(1));
            cnt_n   = '0;
            state_n = LOAD;
          end else begin
            state_n = ABORT;
          end
        end
      end
      LOAD: begin
        if (sw_abort) begin
          state_n = ABORT;
        end else if (wr_sel && !rd_sel) begin
          state_n = ABORT;
        end else if (rd_sel && wr_sel) begin
          state_n = DONE;
        end else if (rd_sel) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else if (tmo_hit) begin
          state_n = ABORT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DRAIN: begin
        if (sw_abort) begin
          state_n = ABORT;
        end else if (wr_sel) begin
          state_n = DONE;
        end else if (tmo_hit) begin
          state_n = ABORT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DONE:    state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track state_q
  always_comb begin
    oh_n     = NUM_ACC'(1) << ch_n;
    enable_d = '0;
    put_d    = '0;
    get_d    = '0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    busy_d   = 1'b1;
    case (state_n)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      LOAD: begin
        enable_d = oh_n;
        put_d    = oh_n;
        get_d    = oh_n;
      end
      DRAIN: begin
        enable_d = oh_n;
        get_d    = oh_n;
      end
      DONE:    done_d  = 1'b1;
      ABORT:   error_d = 1'b1;
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Structural invariants on the registered outputs
  a_enable_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(acc_enable));
  a_req_in_enable : assert property (@(posedge clk) disable iff (!reset)
    ((put_req | get_req) & ~acc_enable) == '0);
  a_done_xor_err : assert property (@(posedge clk) disable iff (!reset)
    !(acc_done && acc_error));
  a_ready_vs_busy : assert property (@(posedge clk) disable iff (!reset)
    instr_ready != busy);

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Scoreboard bench for acc_ctrl_seq: stimulus queues per-cycle expected outputs,
// a negedge monitor compares them and flags any unscheduled done/error pulse.
module tb_acc_ctrl_seq;

  localparam int S_IDLE = 0, S_LOAD = 1, S_DRAIN = 2, S_DONE = 3, S_ABORT = 4;

  typedef struct {
    int          cyc;
    logic [14:0] v;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Instance A: three channels, 8-cycle watchdog
  logic       a_valid = 1'b0, a_abort = 1'b0;
  logic [1:0] a_op = '0;
  logic [2:0] a_rd = '0, a_wr = '0;
  logic [2:0] a_en, a_put, a_get;
  logic       a_rdy, a_rre, a_rwe, a_done, a_err, a_busy;

  // Instance B: two channels, watchdog disabled
  logic       b_valid = 1'b0, b_abort = 1'b0;
  logic [1:0] b_op = '0;
  logic [1:0] b_rd = '0, b_wr = '0;
  logic [1:0] b_en, b_put, b_get;
  logic       b_rdy, b_rre, b_rwe, b_done, b_err, b_busy;

  acc_ctrl_seq #(.NUM_ACC(3), .OP_W(2), .TMO_W(16), .TMO_CYC(16'd8)) dut_a (
    .clk(clk), .reset(reset), .instr_valid(a_valid), .instr_op(a_op),
    .instr_ready(a_rdy), .sw_abort(a_abort), .read_done(a_rd), .write_done(a_wr),
    .acc_enable(a_en), .put_req(a_put), .get_req(a_get),
    .ram_read_enable(a_rre), .ram_write_enable(a_rwe),
    .acc_done(a_done), .acc_error(a_err), .busy(a_busy)
  );

  acc_ctrl_seq #(.NUM_ACC(2), .OP_W(2), .TMO_W(16), .TMO_CYC(16'd0)) dut_b (
    .clk(clk), .reset(reset), .instr_valid(b_valid), .instr_op(b_op),
    .instr_ready(b_rdy), .sw_abort(b_abort), .read_done(b_rd), .write_done(b_wr),
    .acc_enable(b_en), .put_req(b_put), .get_req(b_get),
    .ram_read_enable(b_rre), .ram_write_enable(b_rwe),
    .acc_done(b_done), .acc_error(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector {en,put,get,rre,rwe,done,err,rdy,busy} for a state
  function automatic logic [14:0] vec(input int st, input int ch);
    logic [2:0] oh;
    oh = 3'b001 << ch;
    case (st)
      S_LOAD:  return {oh, oh, oh, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      S_DRAIN: return {oh, 3'b000, oh, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      S_DONE:  return {9'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      S_ABORT: return {9'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      default: return {9'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    endcase
  endfunction

  task automatic chk(input int inst, input int st, input int ch, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.v   = vec(st, ch);
    e.nm  = nm;
    if (inst == 0) qa.push_back(e);
    else           qb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ca(input int st, input int ch, input string nm);
    chk(0, st, ch, nm);
    step();
  endtask

  task automatic cb(input int st, input int ch, input string nm);
    chk(1, st, ch, nm);
    step();
  endtask

  task automatic mon(input int inst, input logic [14:0] act);
    exp_t e;
    bit   hit;
    hit = 1'b0;
    while (1) begin
      if (inst == 0) begin
        if (qa.size() == 0 || qa[0].cyc > cyc) break;
        e = qa.pop_front();
      end else begin
        if (qb.size() == 0 || qb[0].cyc > cyc) break;
        e = qb.pop_front();
      end
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check not sampled, scheduled cycle %0d, now %0d", e.nm, e.cyc, cyc);
      end else begin
        hit = 1'b1;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b required %b (cycle %0d, inst %0d)", e.nm, act, e.v, cyc, inst);
        end
      end
    end
    if (!hit && (act[3] || act[2])) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse: inst %0d got done=%b error=%b required none (cycle %0d)",
               inst, act[3], act[2], cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, {a_en, a_put, a_get, a_rre, a_rwe, a_done, a_err, a_rdy, a_busy});
    mon(1, {1'b0, b_en, 1'b0, b_put, 1'b0, b_get, b_rre, b_rwe, b_done, b_err, b_rdy, b_busy});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    step();
    chk(0, S_IDLE, 0, "reset_a");
    chk(1, S_IDLE, 0, "reset_b");
    step();
    reset = 1'b1;
    ca(S_IDLE, 0, "post_reset");

    // Normal run on channel 1, with an opcode offered while busy
    a_valid = 1'b1; a_op = 2'd2; ca(S_IDLE, 0, "n_accept");
    a_valid = 1'b0;              ca(S_LOAD, 1, "n_load1");
    a_valid = 1'b1; a_op = 2'd3; ca(S_LOAD, 1, "n_load_busy_op");
    a_valid = 1'b0; a_rd = 3'b010; ca(S_LOAD, 1, "n_load_rd");
    a_rd = '0;                   ca(S_DRAIN, 1, "n_drain1");
                                 ca(S_DRAIN, 1, "n_drain2");
    a_wr = 3'b010;               ca(S_DRAIN, 1, "n_drain_wr");
    a_wr = '0;                   ca(S_DONE, 0, "n_done");
                                 ca(S_IDLE, 0, "n_idle");

    // Simultaneous done skips DRAIN
    a_valid = 1'b1; a_op = 2'd3; ca(S_IDLE, 0, "sim_accept");
    a_valid = 1'b0; a_rd = 3'b100; a_wr = 3'b100; ca(S_LOAD, 2, "sim_load");
    a_rd = '0; a_wr = '0;        ca(S_DONE, 0, "sim_done");
                                 ca(S_IDLE, 0, "sim_idle");

    // NOP opcode does nothing
    a_valid = 1'b1; a_op = 2'd0; ca(S_IDLE, 0, "nop_0");
    a_valid = 1'b0;              ca(S_IDLE, 0, "nop_1");

    // Protocol error: write_done before read_done
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "perr_accept");
    a_valid = 1'b0; a_wr = 3'b001; ca(S_LOAD, 0, "perr_load");
    a_wr = '0;                   ca(S_ABORT, 0, "perr_abort");
                                 ca(S_IDLE, 0, "perr_idle");

    // Invalid opcode on the two-channel instance
    b_valid = 1'b1; b_op = 2'd3; cb(S_IDLE, 0, "inv_accept");
    b_valid = 1'b0;              cb(S_ABORT, 0, "inv_abort");
                                 cb(S_IDLE, 0, "inv_idle");

    // Watchdog fires after eight LOAD cycles
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "tmo_accept");
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) ca(S_LOAD, 0, "tmo_load");
    ca(S_ABORT, 0, "tmo_abort");
    ca(S_IDLE, 0, "tmo_idle");

    // Done on the eighth LOAD cycle beats the watchdog
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "tmo_win_accept");
    a_valid = 1'b0;
    for (int i = 0; i < 7; i++) ca(S_LOAD, 0, "tmo_win_load");
    a_rd = 3'b001; a_wr = 3'b001; ca(S_LOAD, 0, "tmo_win_8th");
    a_rd = '0; a_wr = '0;        ca(S_DONE, 0, "tmo_win_done");
                                 ca(S_IDLE, 0, "tmo_win_idle");

    // Watchdog restarts on DRAIN entry
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "dtmo_accept");
    a_valid = 1'b0; a_rd = 3'b001; ca(S_LOAD, 0, "dtmo_load");
    a_rd = '0;
    for (int i = 0; i < 8; i++) ca(S_DRAIN, 0, "dtmo_drain");
    ca(S_ABORT, 0, "dtmo_abort");
    ca(S_IDLE, 0, "dtmo_idle");

    // sw_abort in DRAIN beats write_done
    a_valid = 1'b1; a_op = 2'd2; ca(S_IDLE, 0, "ab_accept");
    a_valid = 1'b0; a_rd = 3'b010; ca(S_LOAD, 1, "ab_load");
    a_rd = '0; a_abort = 1'b1; a_wr = 3'b010; ca(S_DRAIN, 1, "ab_drain");
    a_abort = 1'b0; a_wr = '0;   ca(S_ABORT, 0, "ab_abort");
                                 ca(S_IDLE, 0, "ab_idle");

    // sw_abort ignored in IDLE, then beats a full done in LOAD
    a_abort = 1'b1; a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "ab_idle_ignored");
    a_valid = 1'b0; a_rd = 3'b001; a_wr = 3'b001; ca(S_LOAD, 0, "ab_load_prio");
    a_abort = 1'b0; a_rd = '0; a_wr = '0; ca(S_ABORT, 0, "ab_prio_abort");
                                 ca(S_IDLE, 0, "ab_prio_idle");

    // Cross-channel strobes are ignored
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "x_accept");
    a_valid = 1'b0; a_rd = 3'b110; a_wr = 3'b110; ca(S_LOAD, 0, "x_load1");
    a_rd = 3'b010; a_wr = 3'b100; ca(S_LOAD, 0, "x_load2");
    a_rd = 3'b100; a_wr = 3'b000; ca(S_LOAD, 0, "x_load3");
    a_rd = 3'b001;               ca(S_LOAD, 0, "x_load_rd");
    a_rd = 3'b110; a_wr = 3'b110; ca(S_DRAIN, 0, "x_drain1");
    a_rd = '0; a_wr = 3'b001;    ca(S_DRAIN, 0, "x_drain_wr");
    a_wr = '0;                   ca(S_DONE, 0, "x_done");
                                 ca(S_IDLE, 0, "x_idle");

    // Disabled watchdog: long LOAD never aborts
    b_valid = 1'b1; b_op = 2'd2; cb(S_IDLE, 0, "nt_accept");
    b_valid = 1'b0;
    for (int i = 0; i < 20; i++) cb(S_LOAD, 1, "nt_load");
    b_rd = 2'b10; b_wr = 2'b10;  cb(S_LOAD, 1, "nt_load_done");
    b_rd = '0; b_wr = '0;        cb(S_DONE, 0, "nt_done");
                                 cb(S_IDLE, 0, "nt_idle");

    // Reset mid-LOAD clears outputs before the next edge, no pulse issued
    a_valid = 1'b1; a_op = 2'd1; ca(S_IDLE, 0, "rst_accept");
    a_valid = 1'b0;              ca(S_LOAD, 0, "rst_load");
    reset = 1'b0;                ca(S_IDLE, 0, "rst_async");
                                 ca(S_IDLE, 0, "rst_hold");
    reset = 1'b1;                ca(S_IDLE, 0, "rst_release");
    a_valid = 1'b1; a_op = 2'd3; ca(S_IDLE, 0, "rst_accept2");
    a_valid = 1'b0; a_rd = 3'b100; a_wr = 3'b100; ca(S_LOAD, 2, "rst_load2");
    a_rd = '0; a_wr = '0;        ca(S_DONE, 0, "rst_done2");
                                 ca(S_IDLE, 0, "rst_idle2");

    step();
    step();
    if (qa.size() != 0 || qb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: got %0d/%0d pending entries required 0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
